// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding and the sequencer state type.
package muldiv_pkg;

  // Operation encoding on the op input: bit 1 selects divide, bit 0 signed.
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    CALC = 2'b10,
    FIX  = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiplies by radix-2 shift-add and divides by restoring shift-subtract
// on magnitudes. Signs are removed in PREP and restored in FIX, so the
// latency is the same for every operand pattern.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int ACC_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};

  state_e             state_r;
  state_e             state_next_s;
  logic               busy_r;
  logic               done_r;
  logic               is_div_r;
  logic               sign_a_r;
  logic               sign_b_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               op_is_div_s;
  logic               op_is_signed_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_fits_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [ACC_W-1:0]   acc_step_s;
  logic               neg_q_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;

  // Conditional two's-complement of one WIDTH-bit word. cin is the carry
  // into this word: 1 for a standalone value; for the upper half of a
  // 2*WIDTH value it is the borrow-free condition "lower half is zero".
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg,
                                                input logic cin);
    if (neg) begin
      cond_neg = ~v + {{(WIDTH-1){1'b0}}, cin};
    end else begin
      cond_neg = v;
    end
  endfunction

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Next-state logic; flush returns any active sequence to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && !flush) begin
          state_next_s = PREP;
        end else begin
          state_next_s = IDLE;
        end
      end
      PREP: begin
        if (flush) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_next_s = IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          state_next_s = FIX;
        end else begin
          state_next_s = CALC;
        end
      end
      FIX: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath helpers: operand decode, magnitudes, one iteration step, and
  // sign-corrected results.
  always_comb begin
    op_is_div_s    = (op == OP_DIVU) || (op == OP_DIV);
    op_is_signed_s = (op == OP_MULT) || (op == OP_DIV);
    abs_a_s        = cond_neg(a_r, sign_a_r, 1'b1);
    abs_b_s        = cond_neg(b_r, sign_b_r, 1'b1);

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift right with the carry.
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[ACC_W-1:WIDTH]} + {1'b0, a_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[ACC_W-1:WIDTH]};
    end

    // Divide: partial remainder shifted left with the next dividend bit.
    // Because remainder < divisor, a successful difference fits in WIDTH bits.
    div_shift_s = acc_r[ACC_W-1:WIDTH-1];
    div_fits_s  = (div_shift_s >= {1'b0, b_r});
    div_diff_s  = div_shift_s[WIDTH-1:0] - b_r;

    if (!is_div_r) begin
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else if (div_fits_s) begin
      acc_step_s = {div_diff_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_step_s = {acc_r[ACC_W-2:0], 1'b0};
    end

    // Product and quotient take sign a^b; remainder takes the dividend sign.
    // Most-negative / -1 yields quotient 2^(WIDTH-1) whose negation is itself.
    neg_q_s = sign_a_r ^ sign_b_r;
    if (!is_div_r) begin
      res_lo_s = cond_neg(acc_r[WIDTH-1:0], neg_q_s, 1'b1);
      res_hi_s = cond_neg(acc_r[ACC_W-1:WIDTH], neg_q_s,
                          (acc_r[WIDTH-1:0] == W_ZERO));
    end else if (b_r == W_ZERO) begin
      res_lo_s = W_ONES;
      res_hi_s = cond_neg(a_r, sign_a_r, 1'b1);
    end else begin
      res_lo_s = cond_neg(acc_r[WIDTH-1:0], neg_q_s, 1'b1);
      res_hi_s = cond_neg(acc_r[ACC_W-1:WIDTH], sign_a_r, 1'b1);
    end
  end

  // Operand capture, iteration, HI/LO update and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      is_div_r <= 1'b0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      a_r      <= W_ZERO;
      b_r      <= W_ZERO;
      acc_r    <= {ACC_W{1'b0}};
      cnt_r    <= CNT_ZERO;
      hi_r     <= W_ZERO;
      lo_r     <= W_ZERO;
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (hi_we) begin
            hi_r <= wdata;
          end
          if (lo_we) begin
            lo_r <= wdata;
          end
          if (start && !flush) begin
            a_r      <= rs_val;
            b_r      <= rt_val;
            is_div_r <= op_is_div_s;
            sign_a_r <= op_is_signed_s & rs_val[WIDTH-1];
            sign_b_r <= op_is_signed_s & rt_val[WIDTH-1];
          end
        end
        PREP: begin
          if (!flush) begin
            a_r   <= abs_a_s;
            b_r   <= abs_b_s;
            cnt_r <= CNT_LAST;
            if (is_div_r) begin
              acc_r <= {W_ZERO, abs_a_s};
            end else begin
              acc_r <= {W_ZERO, abs_b_s};
            end
          end
        end
        CALC: begin
          if (!flush) begin
            acc_r <= acc_step_s;
            if (cnt_r != CNT_ZERO) begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
        end
        FIX: begin
          if (!flush) begin
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
            done_r <= 1'b1;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// flush/write/reset sequences, and randomized ops against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 3;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic          flush  = 1'b0;
  logic          hi_we  = 1'b0;
  logic          lo_we  = 1'b0;
  logic [1:0]    op     = 2'b00;
  logic [W-1:0]  rs_val = 32'h0;
  logic [W-1:0]  rt_val = 32'h0;
  logic [W-1:0]  wdata  = 32'h0;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic with the special cases.
  function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    output logic [W-1:0] rh, output logic [W-1:0] rl);
    logic [63:0] p;
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        rh = p[63:32]; rl = p[31:0];
      end
      OP_MULT: begin
        p = sa * sb;
        rh = p[63:32]; rl = p[31:0];
      end
      OP_DIVU: begin
        if (b == 32'h0) begin
          rl = 32'hFFFF_FFFF; rh = a;
        end else begin
          rl = a / b; rh = a % b;
        end
      end
      default: begin
        if (b == 32'h0) begin
          rl = 32'hFFFF_FFFF; rh = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000; rh = 32'h0;
        end else begin
          p = sa / sb; rl = p[31:0];
          p = sa % sb; rh = p[31:0];
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op at the current negedge (cycle N) and walk to cycle N+35.
  // poke_at>0 drives a stray start plus HI/LO writes during that busy cycle;
  // wr_early writes LO together with the start.
  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input int poke_at, input bit wr_early);
    int bad;
    bad = 0;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    if (wr_early) begin
      lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    end
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      if (k == 1 && wr_early) check({name, " early_lo"}, lo, 32'hA5A5_A5A5);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (k == poke_at) begin
        start = 1'b1; op = OP_MULTU; rs_val = 32'h3; rt_val = 32'h3;
        lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    end
    check({name, " busy_window_bad_cycles"}, bad, 0);
    check({name, " busy_done_at_N+35"}, {busy, done}, 2'b01);
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   o;
    logic [W-1:0] a, b, eh, el;
    int           cnt;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[3] = '{OP_DIVU,  32'd10,        32'd0,         32'h0000_000A, 32'hFFFF_FFFF};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[6] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    // Reset state
    #1;
    check("reset_state", {busy, done, hi, lo}, 66'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, 0, 1'b0);
      @(negedge clk);
    end

    // Back-to-back: second start issued in the done cycle of the first
    run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1'b0);
    run_op("mult_7x7_b2b", OP_MULT, 32'd7, 32'd7, 32'h0, 32'h31, 0, 1'b0);
    @(negedge clk);

    // MTHI preload, then flush mid-divide
    hi_we = 1'b1; wdata = 32'h11;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", hi, 32'h11);
    op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_N+11", busy, 1'b0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 1'b0) cnt++;
      @(negedge clk);
    end
    check("flush_no_done", cnt, 0);
    check("flush_hi_kept", hi, 32'h11);
    check("flush_lo_kept", lo, 32'h31);

    // flush in IDLE cancels a simultaneous start
    op = OP_MULTU; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_cancels_start", busy, 1'b0);
    @(negedge clk);
    check("idle_flush_still_idle", {busy, done}, 2'b00);

    // Stray start and MTLO/MTHI mid-operation ignored; LO write with start lands first
    run_op("poke_mid_op", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5, 1'b1);
    @(negedge clk);

    // Asynchronous reset mid-operation
    op = OP_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {busy, done, hi, lo}, 66'h0);
    @(negedge clk);
    check("reset_held", {busy, done, hi, lo}, 66'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_reset_3x4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 0, 1'b0);

    // Randomized ops against the reference model, some back-to-back
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      ref_model(o, a, b, eh, el);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op($sformatf("rnd%0d_op%0d_%h_%h", i, o, a, b), o, a, b, eh, el, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
